// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing defaults, datapath widths, raster flag payload and
// pattern encodings for the VGA frame sequencer and its timing generator.
package vga_timing_pkg;

    localparam int unsigned H_SYNC_PX   = 96;
    localparam int unsigned H_BACK_PX   = 48;
    localparam int unsigned H_ACTIVE_PX = 640;
    localparam int unsigned H_FRONT_PX  = 16;
    localparam int unsigned H_TOTAL_PX  = H_SYNC_PX + H_BACK_PX + H_ACTIVE_PX + H_FRONT_PX;

    localparam int unsigned V_SYNC_LN   = 2;
    localparam int unsigned V_BACK_LN   = 33;
    localparam int unsigned V_ACTIVE_LN = 480;
    localparam int unsigned V_FRONT_LN  = 10;
    localparam int unsigned V_TOTAL_LN  = V_SYNC_LN + V_BACK_LN + V_ACTIVE_LN + V_FRONT_LN;

    // Counter width sized for the larger of the two raster totals.
    localparam int unsigned CNT_W = $clog2((H_TOTAL_PX > V_TOTAL_LN) ? H_TOTAL_PX : V_TOTAL_LN);
    localparam int unsigned RGB_W = 16;
    localparam int unsigned PAT_W = 2;

    typedef logic [PAT_W-1:0] pattern_t;

    typedef enum logic [PAT_W-1:0] {
        COLORBAR = 2'd0,
        GRID     = 2'd1,
        GRADIENT = 2'd2,
        SOLID    = 2'd3
    } pattern_e;

    typedef struct packed {
        logic hsync_n;
        logic vsync_n;
        logic de;
        logic first;
    } raster_flags_t;

    localparam raster_flags_t FLAGS_IDLE = '{hsync_n: 1'b1, vsync_n: 1'b1, de: 1'b0, first: 1'b0};

    // Wraps num-1 back to COLORBAR; a single-pattern set stays on COLORBAR.
    function automatic pattern_t next_pattern(input pattern_t cur, input int unsigned num);
        pattern_t nxt;
        nxt = pattern_t'(COLORBAR);
        if ((num > 1) && (32'(cur) < (num - 1))) begin
            nxt = cur + PAT_W'(1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Raster counters (hcnt/vcnt) plus combinational sync, active, frame-first and
// frame-boundary flags decoded from the current counter value.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_SYNC   = H_SYNC_PX,
    parameter int unsigned H_BACK   = H_BACK_PX,
    parameter int unsigned H_ACTIVE = H_ACTIVE_PX,
    parameter int unsigned H_FRONT  = H_FRONT_PX,
    parameter int unsigned V_SYNC   = V_SYNC_LN,
    parameter int unsigned V_BACK   = V_BACK_LN,
    parameter int unsigned V_ACTIVE = V_ACTIVE_LN,
    parameter int unsigned V_FRONT  = V_FRONT_LN
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [CNT_W-1:0] o_hcnt,
    output logic [CNT_W-1:0] o_vcnt,
    output raster_flags_t    o_flags_c,
    output logic             o_boundary_c
);

    localparam int unsigned H_TOTAL  = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int unsigned V_TOTAL  = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
    localparam int unsigned H_ACT_LO = H_SYNC + H_BACK;
    localparam int unsigned H_ACT_HI = H_ACT_LO + H_ACTIVE;
    localparam int unsigned V_ACT_LO = V_SYNC + V_BACK;
    localparam int unsigned V_ACT_HI = V_ACT_LO + V_ACTIVE;

    if ((H_TOTAL > (2 ** CNT_W)) || (V_TOTAL > (2 ** CNT_W))) begin : g_bad_size
        $error("vga_timing_gen: raster totals exceed counter width");
    end

    logic [CNT_W-1:0] r_hcnt;
    logic [CNT_W-1:0] r_vcnt;
    logic [CNT_W-1:0] w_hcnt_nxt;
    logic [CNT_W-1:0] w_vcnt_nxt;
    logic             w_h_last;
    logic             w_v_last;
    logic             w_h_act;
    logic             w_v_act;

    assign w_h_last = (r_hcnt == CNT_W'(H_TOTAL - 1));
    assign w_v_last = (r_vcnt == CNT_W'(V_TOTAL - 1));

    // vcnt steps only on the last pixel of a line.
    always_comb begin
        w_hcnt_nxt = r_hcnt + CNT_W'(1);
        w_vcnt_nxt = r_vcnt;
        if (w_h_last) begin
            w_hcnt_nxt = '0;
            w_vcnt_nxt = w_v_last ? '0 : (r_vcnt + CNT_W'(1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hcnt <= '0;
            r_vcnt <= '0;
        end else begin
            r_hcnt <= w_hcnt_nxt;
            r_vcnt <= w_vcnt_nxt;
        end
    end

    assign w_h_act = (r_hcnt >= CNT_W'(H_ACT_LO)) && (r_hcnt < CNT_W'(H_ACT_HI));
    assign w_v_act = (r_vcnt >= CNT_W'(V_ACT_LO)) && (r_vcnt < CNT_W'(V_ACT_HI));

    always_comb begin
        o_flags_c         = FLAGS_IDLE;
        o_flags_c.hsync_n = (r_hcnt >= CNT_W'(H_SYNC));
        o_flags_c.vsync_n = (r_vcnt >= CNT_W'(V_SYNC));
        o_flags_c.de      = w_h_act && w_v_act;
        o_flags_c.first   = (r_hcnt == '0) && (r_vcnt == '0);
    end

    assign o_boundary_c = w_h_last && w_v_last;
    assign o_hcnt       = r_hcnt;
    assign o_vcnt       = r_vcnt;

endmodule

// File: rtl/vga_frame_sequencer.sv
// VGA raster timing, pattern scheduling and 3-stage output alignment around an
// external RGB565 generator. Define VGA_SEQ_AUTO_EN for frame-counted auto advance.
module vga_frame_sequencer
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_SYNC             = H_SYNC_PX,
    parameter int unsigned H_BACK             = H_BACK_PX,
    parameter int unsigned H_ACTIVE           = H_ACTIVE_PX,
    parameter int unsigned H_FRONT            = H_FRONT_PX,
    parameter int unsigned V_SYNC             = V_SYNC_LN,
    parameter int unsigned V_BACK             = V_BACK_LN,
    parameter int unsigned V_ACTIVE           = V_ACTIVE_LN,
    parameter int unsigned V_FRONT            = V_FRONT_LN,
    parameter int unsigned FRAMES_PER_PATTERN = 60,
    parameter int unsigned NUM_PATTERNS       = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pause,
    input  logic             step,
    input  logic [RGB_W-1:0] pix_data,
    output logic             pix_req,
    output logic [CNT_W-1:0] pix_x,
    output logic [CNT_W-1:0] pix_y,
    output logic [PAT_W-1:0] pattern_sel,
    output logic [RGB_W-1:0] rgb_565,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic             frame_start
);

    localparam int unsigned H_ACT_LO = H_SYNC + H_BACK;
    localparam int unsigned V_ACT_LO = V_SYNC + V_BACK;

    if ((FRAMES_PER_PATTERN < 1) || (NUM_PATTERNS < 1) || (NUM_PATTERNS > (2 ** PAT_W))) begin : g_bad_cfg
        $error("vga_frame_sequencer: unsupported FRAMES_PER_PATTERN/NUM_PATTERNS");
    end

    logic [CNT_W-1:0] w_hcnt;
    logic [CNT_W-1:0] w_vcnt;
    raster_flags_t    w_flags;
    logic             w_boundary;

    vga_timing_gen #(
        .H_SYNC   (H_SYNC),
        .H_BACK   (H_BACK),
        .H_ACTIVE (H_ACTIVE),
        .H_FRONT  (H_FRONT),
        .V_SYNC   (V_SYNC),
        .V_BACK   (V_BACK),
        .V_ACTIVE (V_ACTIVE),
        .V_FRONT  (V_FRONT)
    ) u_timing (
        .clk          (clk),
        .rst_n        (rst_n),
        .o_hcnt       (w_hcnt),
        .o_vcnt       (w_vcnt),
        .o_flags_c    (w_flags),
        .o_boundary_c (w_boundary)
    );

    pattern_t r_pattern;
    pattern_t w_pattern_nxt;
    logic     r_step_pend;
    logic     w_step_pend_nxt;
    logic     w_step_req;
    logic     w_advance;

`ifdef VGA_SEQ_AUTO_EN
    localparam int unsigned FCNT_W = (FRAMES_PER_PATTERN > 1) ? $clog2(FRAMES_PER_PATTERN) : 1;

    logic [FCNT_W-1:0] r_fcnt;
    logic [FCNT_W-1:0] w_fcnt_nxt;
    logic              w_auto_due;

    assign w_auto_due = !pause && (r_fcnt == FCNT_W'(FRAMES_PER_PATTERN - 1));
`else
    logic w_unused_pause;
    assign w_unused_pause = pause;
`endif

    // A step in the boundary cycle itself is honoured at that boundary; any
    // number of steps plus an auto advance still move the pattern by one.
    always_comb begin
        w_step_req      = r_step_pend | step;
        w_step_pend_nxt = w_step_req;
        w_advance       = 1'b0;
        w_pattern_nxt   = r_pattern;
`ifdef VGA_SEQ_AUTO_EN
        w_fcnt_nxt      = r_fcnt;
`endif
        if (w_boundary) begin
            w_step_pend_nxt = 1'b0;
`ifdef VGA_SEQ_AUTO_EN
            w_advance = w_step_req | w_auto_due;
            if (w_advance) begin
                w_fcnt_nxt = '0;
            end else if (!pause) begin
                w_fcnt_nxt = r_fcnt + FCNT_W'(1);
            end
`else
            w_advance = w_step_req;
`endif
            if (w_advance) begin
                w_pattern_nxt = next_pattern(r_pattern, NUM_PATTERNS);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pattern   <= pattern_t'(COLORBAR);
            r_step_pend <= 1'b0;
        end else begin
            r_pattern   <= w_pattern_nxt;
            r_step_pend <= w_step_pend_nxt;
        end
    end

`ifdef VGA_SEQ_AUTO_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fcnt <= '0;
        end else begin
            r_fcnt <= w_fcnt_nxt;
        end
    end
`endif

    logic [CNT_W-1:0] r_pix_x;
    logic [CNT_W-1:0] r_pix_y;
    logic             r_pix_req;
    raster_flags_t    r_s1;
    raster_flags_t    r_s2;
    logic [RGB_W-1:0] r_rgb;
    logic             r_hsync;
    logic             r_vsync;
    logic             r_de;
    logic             r_frame_start;

    // Stage 1 requests a pixel, stage 2 waits on the generator, stage 3 drives pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pix_req     <= 1'b0;
            r_pix_x       <= '0;
            r_pix_y       <= '0;
            r_s1          <= FLAGS_IDLE;
            r_s2          <= FLAGS_IDLE;
            r_rgb         <= '0;
            r_hsync       <= 1'b1;
            r_vsync       <= 1'b1;
            r_de          <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_pix_req     <= w_flags.de;
            r_pix_x       <= w_flags.de ? (w_hcnt - CNT_W'(H_ACT_LO)) : '0;
            r_pix_y       <= w_flags.de ? (w_vcnt - CNT_W'(V_ACT_LO)) : '0;
            r_s1          <= w_flags;
            r_s2          <= r_s1;
            r_rgb         <= r_s2.de ? pix_data : '0;
            r_hsync       <= r_s2.hsync_n;
            r_vsync       <= r_s2.vsync_n;
            r_de          <= r_s2.de;
            r_frame_start <= r_s2.first;
        end
    end

    assign pix_req     = r_pix_req;
    assign pix_x       = r_pix_x;
    assign pix_y       = r_pix_y;
    assign pattern_sel = r_pattern;
    assign rgb_565     = r_rgb;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign de          = r_de;
    assign frame_start = r_frame_start;

endmodule

// File: doc/vga_frame_sequencer.md
# vga_frame_sequencer

Timing controller and pattern scheduler for the VGA colour-bar datapath. Generates 640x480@60 raster timing, issues per-pixel coordinate requests to the pattern generator, and aligns the generator's registered RGB565 response with hsync/vsync/de. Selects which test pattern the generator draws, advancing it on frame boundaries automatically or on request. Sits between the pixel clock domain root and the DAC/RGB565 output pins.

## Interface
- H_SYNC, 96, hsync pulse width in clocks
- H_BACK, 48, horizontal back porch
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (line total 800)
- V_SYNC, 2, vsync pulse width in lines
- V_BACK, 33, vertical back porch
- V_ACTIVE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (frame total 525)
- FRAMES_PER_PATTERN, 60, frames shown per pattern in auto mode (>=1)
- NUM_PATTERNS, 4, number of patterns cycled (1..4)

- clk  in  1  pixel clock
- rst_n  in  1  asynchronous, active-low reset
- pause  in  1  level; suppresses auto advance
- step  in  1  single-cycle pulse; request one pattern advance
- pix_data  in  16  RGB565 from generator, valid 1 cycle after pix_req
- pix_req  out  1  coordinate valid (active region)
- pix_x  out  10  column 0..H_ACTIVE-1, 0 outside active
- pix_y  out  10  row 0..V_ACTIVE-1, 0 outside active
- pattern_sel  out  2  current pattern index to generator
- rgb_565  out  16  pixel output, 0 when de=0
- hsync  out  1  active-low
- vsync  out  1  active-low
- de  out  1  display enable, aligned with rgb_565
- frame_start  out  1  one-cycle pulse, first clock of a frame at output stage

## Operation
- hcnt 0..799, vcnt 0..524; hcnt wraps to 0 and vcnt increments at hcnt=799; vcnt wraps at 524.
- hsync low for hcnt 0..H_SYNC-1; vsync low for vcnt 0..V_SYNC-1.
- Active when hcnt in [H_SYNC+H_BACK, +H_ACTIVE) and vcnt in [V_SYNC+V_BACK, +V_ACTIVE); pix_x=hcnt-144, pix_y=vcnt-35.
- Frame boundary = hcnt=799 and vcnt=524.
- Frame counter 0..FRAMES_PER_PATTERN-1 increments at each boundary unless pause=1 (holds); at terminal count with pause=0, pattern advances and counter clears.
- step pulse sets a pending flag; applied at next boundary then cleared; multiple steps before a boundary collapse to one advance. step applies regardless of pause and clears the frame counter.
- Auto advance and pending step at the same boundary: advance by exactly one.
- pattern_sel wraps NUM_PATTERNS-1 -> 0; NUM_PATTERNS=1 holds 0.
- pattern_sel never changes except in the cycle where counters wrap to (0,0).

## Timing
- Stage 0: counters at cycle n. Stage 1 (n+1): pix_req/pix_x/pix_y/pattern_sel registered. Stage 2 (n+2): generator pix_data. Stage 3 (n+3): rgb_565, hsync, vsync, de, frame_start registered.
- hsync/vsync/de delayed through a 3-stage shift so all output-stage signals reflect the same counter value.
- rgb_565 = de ? pix_data(registered) : 0.
- Reset values: hcnt=vcnt=0, frame counter 0, pending step 0, pix_req=0, pix_x=pix_y=0, pattern_sel=0, rgb_565=0, hsync=1, vsync=1, de=0, frame_start=0, delay pipeline cleared to inactive (sync high).
- Reset mid-frame: all outputs return to reset values immediately (asynchronous); raster restarts at (0,0) on release, first frame_start 3 clocks after first active clk edge.

## Configuration
- VGA_SEQ_AUTO_EN defined: frame counter and automatic advance as above.
- Undefined: frame counter removed; pattern advances only on step; pause has no effect; FRAMES_PER_PATTERN ignored.

## Structure
- Package vga_timing_pkg: 640x480 timing constants, line/frame totals, RGB565 width, pattern index type and pattern encoding constants (COLORBAR=0, GRID=1, GRADIENT=2, SOLID=3).
- Sub-module vga_timing_gen: hcnt/vcnt counters, raw sync/active/boundary flags; sequencer logic and output pipeline stay in the top.

## Test plan
- Reset: rst_n=0 -> hsync=1, vsync=1, de=0, rgb_565=0, pattern_sel=0; after release hsync period 800 clocks, low 96; vsync period 420000 clocks, low 1600.
- Active window: de high 640 consecutive clocks per line, 480 lines per frame; pix_x 0..639, pix_y 0..479 with pix_req.
- Alignment: generator model returns pix_data={pix_y[4:0],pix_x[10:0]-truncated}; first de clock of line 0 carries data for (0,0), last for (639,0).
- Auto cycle (FRAMES_PER_PATTERN=2, NUM_PATTERNS=4, small timing params): pattern_sel 0,0,1,1,2,2,3,3,0 per frame.
- Pause/step: pause=1, two step pulses mid-frame -> pattern_sel +1 exactly at next boundary, unchanged thereafter; step coinciding with auto advance -> +1 only.
- Reset at hcnt=400,vcnt=200 -> outputs at reset values same cycle; after release counters restart at 0, pattern_sel=0.
